// File: rtl/m_integral_scalar_unpack_if.sv
// rtl/m_integral_scalar_unpack_if.sv - byte stream in, typed scalar bundle out
interface m_integral_scalar_unpack_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic        frame_err;
   bit          bit_out;
   byte         byte_out;
   int          int_out;
   integer      integer_out;
   logic        logic_out;
   longint      longint_out;
   reg          reg_out;
   shortint     shortint_out;
   int          signed_int_out;
   time         time_out;
   logic [7:0]  unsigned_logic_out;
   logic [15:0] vec_out;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_valid, frame_err,
      output bit_out, byte_out, int_out, integer_out, logic_out, longint_out,
      output reg_out, shortint_out, signed_int_out, time_out,
      output unsigned_logic_out, vec_out
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_valid, frame_err,
      input  bit_out, byte_out, int_out, integer_out, logic_out, longint_out,
      input  reg_out, shortint_out, signed_int_out, time_out,
      input  unsigned_logic_out, vec_out
   );
endinterface

// File: rtl/m_integral_scalar_unpack.sv
// rtl/m_integral_scalar_unpack.sv - 37-byte little-endian frame deserializer into twelve scalars
module m_integral_scalar_unpack (
   input  logic                             clk,
   input  logic                             rst,
   m_integral_scalar_unpack_if.slave        bus
);
   typedef enum logic {COLLECT, DRAIN} state_t;

   localparam logic [5:0] LAST_IDX = 6'd36;

   state_t       state, state_nxt;
   logic [5:0]   cnt, cnt_nxt;
   logic [287:0] shadow;
   logic [295:0] frame;
   logic         accept;
   logic         stall;
   logic         complete;
   logic         shadow_we;
   logic         err_nxt;
   logic         out_valid_nxt;

   // Only the completing byte waits for the previous bundle to be taken.
   assign stall        = (state == COLLECT) && (cnt == LAST_IDX) && bus.out_valid && !bus.out_ready;
   assign bus.in_ready = !stall;
   assign accept       = bus.in_valid && bus.in_ready;
   // Byte 36 is taken straight from the bus so the bundle loads on the accepting edge.
   assign frame        = {bus.in_data, shadow};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      complete  = 1'b0;
      shadow_we = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         COLLECT: begin
            if (accept) begin
               if (cnt == LAST_IDX) begin
                  cnt_nxt = 6'd0;
                  if (bus.in_last) begin
                     complete = 1'b1;
                  end else begin
                     err_nxt   = 1'b1;
                     state_nxt = DRAIN;
                  end
               end else begin
                  shadow_we = 1'b1;
                  if (bus.in_last) begin
                     err_nxt = 1'b1;
                     cnt_nxt = 6'd0;
                  end else begin
                     cnt_nxt = cnt + 6'd1;
                  end
               end
            end
         end
         DRAIN: begin
            if (accept && bus.in_last) begin
               state_nxt = COLLECT;
               cnt_nxt   = 6'd0;
            end
         end
         default: begin
            state_nxt = COLLECT;
            cnt_nxt   = 6'd0;
         end
      endcase

      out_valid_nxt = bus.out_valid;
      if (complete) begin
         out_valid_nxt = 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
         out_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                  <= COLLECT;
         cnt                    <= 6'd0;
         shadow                 <= '0;
         bus.out_valid          <= 1'b0;
         bus.frame_err          <= 1'b0;
         bus.bit_out            <= 1'b0;
         bus.byte_out           <= 8'd0;
         bus.int_out            <= 32'd0;
         bus.integer_out        <= 32'd0;
         bus.logic_out          <= 1'b0;
         bus.longint_out        <= 64'd0;
         bus.reg_out            <= 1'b0;
         bus.shortint_out       <= 16'd0;
         bus.signed_int_out     <= 32'd0;
         bus.time_out           <= 64'd0;
         bus.unsigned_logic_out <= 8'd0;
         bus.vec_out            <= 16'd0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         bus.out_valid <= out_valid_nxt;
         bus.frame_err <= err_nxt;
         if (shadow_we) begin
            shadow[{cnt, 3'b000} +: 8] <= bus.in_data;
         end
         if (complete) begin
            bus.bit_out            <= frame[0];
            bus.byte_out           <= frame[15:8];
            bus.int_out            <= frame[47:16];
            bus.integer_out        <= frame[79:48];
            bus.logic_out          <= frame[80];
            bus.longint_out        <= frame[151:88];
            bus.reg_out            <= frame[152];
            bus.shortint_out       <= frame[175:160];
            bus.signed_int_out     <= frame[207:176];
            bus.time_out           <= frame[271:208];
            bus.unsigned_logic_out <= frame[279:272];
            bus.vec_out            <= frame[295:280];
         end
      end
   end
endmodule

// File: tb/tb_m_integral_scalar_unpack.sv
// tb/tb_m_integral_scalar_unpack.sv - directed scoreboard bench for the scalar unpacker
module tb_m_integral_scalar_unpack;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   m_integral_scalar_unpack_if bus();

   m_integral_scalar_unpack dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          b;
      byte         by;
      int          i;
      integer      ig;
      logic        l;
      longint      li;
      reg          r;
      shortint     si;
      int          s;
      time         t;
      logic [7:0]  ul;
      logic [15:0] v;
   } bundle_t;

   bundle_t    sb[$];
   logic [7:0] fb [0:39];
   int         vecs = 0;
   int         errs = 0;
   int         cyc = 0;
   int         err_pulses = 0;
   int         stall_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.frame_err === 1'b1) err_pulses <= err_pulses + 1;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bundle_t model();
      bundle_t m;
      m.b  = fb[0][0];
      m.by = fb[1];
      m.i  = {fb[5], fb[4], fb[3], fb[2]};
      m.ig = {fb[9], fb[8], fb[7], fb[6]};
      m.l  = fb[10][0];
      m.li = {fb[18], fb[17], fb[16], fb[15], fb[14], fb[13], fb[12], fb[11]};
      m.r  = fb[19][0];
      m.si = {fb[21], fb[20]};
      m.s  = {fb[25], fb[24], fb[23], fb[22]};
      m.t  = {fb[33], fb[32], fb[31], fb[30], fb[29], fb[28], fb[27], fb[26]};
      m.ul = fb[34];
      m.v  = {fb[36], fb[35]};
      return m;
   endfunction

   function automatic bundle_t zero_bundle();
      bundle_t z;
      z.b = 0; z.by = 0; z.i = 0; z.ig = 0; z.l = 0; z.li = 0;
      z.r = 0; z.si = 0; z.s = 0; z.t = 0; z.ul = 0; z.v = 0;
      return z;
   endfunction

   task automatic check_bundle_vs(input string tag, input bundle_t e);
      check({tag, "_bit"},      bus.bit_out,            e.b);
      check({tag, "_byte"},     bus.byte_out,           e.by);
      check({tag, "_int"},      bus.int_out,            e.i);
      check({tag, "_integer"},  bus.integer_out,        e.ig);
      check({tag, "_logic"},    bus.logic_out,          e.l);
      check({tag, "_longint"},  bus.longint_out,        e.li);
      check({tag, "_reg"},      bus.reg_out,            e.r);
      check({tag, "_shortint"}, bus.shortint_out,       e.si);
      check({tag, "_sint"},     bus.signed_int_out,     e.s);
      check({tag, "_time"},     bus.time_out,           e.t);
      check({tag, "_ulogic"},   bus.unsigned_logic_out, e.ul);
      check({tag, "_vec"},      bus.vec_out,            e.v);
   endtask

   task automatic pop_check(input string tag);
      bundle_t e;
      check({tag, "_sb_depth"}, sb.size(), 1);
      check({tag, "_valid"}, bus.out_valid, 1'b1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_bundle_vs(tag, e);
      end
   endtask

   task automatic fill_random();
      for (int k = 0; k < 40; k++) fb[k] = 8'($urandom);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      int n;
      bus.in_data  = d;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      @(negedge clk);
      n = 0;
      while (!bus.in_ready && n < 200) begin
         stall_cnt++;
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("in_ready_timeout", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_frame(input int n);
      for (int k = 0; k < n; k++) send_byte(fb[k], k == n - 1);
   endtask

   task automatic good_frame(input string tag);
      fill_random();
      sb.push_back(model());
      send_frame(37);
      #3;
      pop_check(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bundle_t a;
      int c0, cdone, p0, s0;

      rst           = 1'b1;
      bus.in_data   = 8'd0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #3;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_frame_err", bus.frame_err, 1'b0);
      check("rst_in_ready",  bus.in_ready,  1'b1);
      check_bundle_vs("rst", zero_bundle());
      @(posedge clk);
      #1;

      // Incrementing-pattern frame with known decoded constants.
      for (int k = 0; k < 40; k++) fb[k] = 8'(k + 1);
      sb.push_back(model());
      send_frame(37);
      #3;
      check("inc_byte",    bus.byte_out,           64'h02);
      check("inc_int",     bus.int_out,            64'h06050403);
      check("inc_longint", bus.longint_out,        64'h131211100F0E0D0C);
      check("inc_time",    bus.time_out,           64'h2221201F1E1D1C1B);
      check("inc_vec",     bus.vec_out,            64'h2524);
      check("inc_ulogic",  bus.unsigned_logic_out, 64'h23);
      check("inc_bit",     bus.bit_out,            1'b1);
      check("inc_logic",   bus.logic_out,          1'b1);
      check("inc_reg",     bus.reg_out,            1'b0);
      pop_check("inc");
      @(posedge clk);
      #1;
      check("inc_consumed", bus.out_valid, 1'b0);

      // Back-to-back frames at full rate.
      s0 = stall_cnt;
      fill_random();
      sb.push_back(model());
      c0 = 0;
      for (int k = 0; k < 37; k++) begin
         send_byte(fb[k], k == 36);
         if (k == 0) c0 = cyc;
      end
      #3;
      pop_check("b2b_a");
      fill_random();
      sb.push_back(model());
      send_frame(37);
      cdone = cyc;
      check("b2b_cycle", cdone - c0 + 1, 74);
      #3;
      pop_check("b2b_b");
      check("b2b_no_stall", stall_cnt - s0, 0);
      @(posedge clk);
      #1;

      // Consumer stalls: completing byte waits, held outputs stay put.
      bus.out_ready = 1'b0;
      fill_random();
      a = model();
      sb.push_back(a);
      send_frame(37);
      #3;
      pop_check("stall_a");
      fill_random();
      sb.push_back(model());
      for (int k = 0; k < 36; k++) send_byte(fb[k], 1'b0);
      bus.in_data  = fb[36];
      bus.in_last  = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 1'b0);
      check_bundle_vs("stall_hold", a);
      repeat (3) @(negedge clk);
      check("stall_in_ready_late", bus.in_ready, 1'b0);
      check("stall_valid_held", bus.out_valid, 1'b1);
      check("stall_hold_late_long", bus.longint_out, a.li);
      #1;
      bus.out_ready = 1'b1;
      #1;
      check("stall_release", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      #3;
      pop_check("stall_b");
      @(posedge clk);
      #1;
      check("stall_consumed", bus.out_valid, 1'b0);

      // Short frame: last at k=10.
      p0 = err_pulses;
      fill_random();
      send_frame(11);
      check("short_err_pulse", bus.frame_err, 1'b1);
      check("short_no_valid", bus.out_valid, 1'b0);
      @(posedge clk);
      #1;
      check("short_err_clear", bus.frame_err, 1'b0);
      check("short_err_count", err_pulses - p0, 1);
      good_frame("after_short");

      // Long frame: 40 bytes, last at 39.
      p0 = err_pulses;
      fill_random();
      for (int k = 0; k < 40; k++) begin
         send_byte(fb[k], k == 39);
         if (k == 36) check("long_err_pulse", bus.frame_err, 1'b1);
      end
      @(posedge clk);
      #1;
      check("long_err_count", err_pulses - p0, 1);
      check("long_no_valid", bus.out_valid, 1'b0);
      good_frame("after_long");

      // Reset in the middle of a frame.
      p0 = err_pulses;
      fill_random();
      for (int k = 0; k < 20; k++) send_byte(fb[k], 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #3;
      check_bundle_vs("midrst", zero_bundle());
      check("midrst_valid", bus.out_valid, 1'b0);
      check("midrst_err", bus.frame_err, 1'b0);
      @(posedge clk);
      #1;
      check("midrst_err_count", err_pulses - p0, 0);
      good_frame("after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
